descheduler: RTL and testbench
==============================

DESCHEDULER -- requirements
Module: descheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the width of each data word.
REQ-002 SHALL have parameter OUTPUTS, default 4, giving the number of lanes per frame; only 4 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port data_in, input, DATA_WIDTH bits: the serialized word stream.
REQ-006 SHALL have port valid_in, input, 1 bit: data_in carries a word this cycle.
REQ-007 SHALL have port sof_in, input, 1 bit: the current word is lane 0 of a frame; meaningful only when valid_in=1.
REQ-008 SHALL have ports r0, r1, r2, r3, each output, DATA_WIDTH bits, registered: the de-serialized lanes 0..3.
REQ-009 SHALL have port valid_out, output, 1 bit, registered: one-cycle pulse when r0..r3 update.
REQ-010 SHALL have port frame_err, output, 1 bit, registered: one-cycle error pulse; present only with the macro in REQ-026.

Function
REQ-011 SHALL implement a two-state FSM:
- HUNT: unaligned, waiting for lane 0.
- COLLECT: assembling a frame.
REQ-011 also SHALL keep a 2-bit lane counter ctr and three DATA_WIDTH-bit shadow registers s0..s2.
REQ-012 In HUNT, a cycle with valid_in=1 and sof_in=1 SHALL write data_in to s0, set ctr=1 and move to COLLECT.
REQ-013 In HUNT, a word with valid_in=1 and sof_in=0 SHALL be discarded; state stays HUNT.
REQ-014 In COLLECT, a cycle with valid_in=1, sof_in=0 and ctr in 1..2 SHALL write data_in to s[ctr] and increment ctr.
REQ-015 In COLLECT, a cycle with valid_in=1, sof_in=0 and ctr=3 SHALL:
- load r0<=s0, r1<=s1, r2<=s2, r3<=data_in together on that edge;
- set valid_out=1 for exactly the following cycle;
- set ctr=0 and return to HUNT.
REQ-016 Latency from the lane-3 word's capture edge to r0..r3/valid_out visible SHALL be zero additional cycles (both registered on that same edge).
REQ-017 valid_in=0 SHALL stall: ctr, state, shadows and r0..r3 hold; valid_out=0. Gaps of any length are allowed mid-frame.
REQ-018 In COLLECT, valid_in=1 with sof_in=1 (truncated frame) SHALL discard the partial frame, write data_in to s0, set ctr=1 and stay in COLLECT.
REQ-019 r0..r3 SHALL change only on a completed frame (REQ-015); partial or discarded frames never alter them.
REQ-020 Back-to-back frames SHALL be accepted with no idle cycle: a sof word in the cycle after a lane-3 word starts the next frame, giving one valid_out per 4 words.
REQ-021 ctr SHALL never wrap through 3->0 other than by frame completion (REQ-015).

Reset
REQ-022 While rst=1, outputs SHALL immediately read: r0..r3=0, valid_out=0, frame_err=0.
REQ-023 While rst=1, internal state SHALL immediately read: s0..s2=0, ctr=0, state=HUNT.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release the first accepted word SHALL be a sof word.
REQ-025 On the first edge after rst deasserts, inputs SHALL be processed normally.

Configuration
REQ-026 Macro DESCHEDULER_FRAME_ERR_EN defined: the frame_err port SHALL exist and pulse for one cycle following:
- each truncated frame (REQ-018);
- each discarded non-sof word in HUNT (REQ-013).
REQ-027 Macro DESCHEDULER_FRAME_ERR_EN undefined: the frame_err port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then words A1(sof),A2,A3,A4 on consecutive cycles -> r0..r3=A1..A4 and valid_out=1 for one cycle after the A4 edge.
REQ-029 Two frames back-to-back (8 valid cycles) -> two valid_out pulses 4 cycles apart, with correct lanes in each.
REQ-030 A frame with valid_in=0 for 3 cycles between lanes 1 and 2 -> same r0..r3 as REQ-028, with valid_out delayed 3 cycles.
REQ-031 Words B1(sof),B2 then C1(sof),C2,C3,C4 -> r=C1..C4; no update for B; frame_err pulse after C1 when the macro is defined.
REQ-032 Non-sof word 0x1234 in HUNT -> ignored; r unchanged; frame_err pulse when the macro is defined.
REQ-033 rst pulsed asynchronously after lane 2 -> outputs 0 immediately; a following non-sof word is ignored.

Source files
------------

// File: rtl/descheduler.sv
// -----------------------------------------------------------------------------
// descheduler
//
// Turns a serialized word stream back into frames of four parallel lanes.
// A word flagged with sof_in is lane 0. It and the next three non-sof words are
// gathered, then presented together on r0..r3. valid_out pulses for one cycle
// each time r0..r3 are loaded.
//
// Optional feature (macro DESCHEDULER_FRAME_ERR_EN):
//   If defined, frame_err pulses for one cycle after each truncated frame
//   (a sof word arrives mid-frame) and after each non-sof word dropped while
//   unaligned. If undefined, the port and its logic are absent.
//
// Parameters:
//   DATA_WIDTH  width of each data word
//   OUTPUTS     lanes per frame (only 4 is supported)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   data_in    serialized word stream
//   valid_in   data_in carries a word this cycle; low stalls everything
//   sof_in     current word is lane 0 of a frame
//   r0..r3     registered de-serialized lanes 0..3
//   valid_out  one-cycle pulse when r0..r3 update
//   frame_err  one-cycle framing error pulse (macro-enabled only)
// -----------------------------------------------------------------------------
module descheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int OUTPUTS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  sof_in,
  output logic [DATA_WIDTH-1:0] r0,
  output logic [DATA_WIDTH-1:0] r1,
  output logic [DATA_WIDTH-1:0] r2,
  output logic [DATA_WIDTH-1:0] r3,
`ifdef DESCHEDULER_FRAME_ERR_EN
  output logic                  valid_out,
  output logic                  frame_err
`else
  output logic                  valid_out
`endif
);

  localparam int CTR_W = $clog2(OUTPUTS);
  localparam logic [CTR_W-1:0] LAST_LANE = CTR_W'(OUTPUTS - 1);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  state_t           state, next_state;
  logic [CTR_W-1:0] ctr;
  logic [DATA_WIDTH-1:0] s0, s1, s2;

  // One-hot per cycle: which action the current word triggers.
  logic take_sof;   // word is lane 0: restart frame in s0
  logic take_mid;   // word is lane 1 or 2: store in s[ctr]
  logic complete;   // word is lane 3: publish frame
`ifdef DESCHEDULER_FRAME_ERR_EN
  logic err;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    take_sof   = 1'b0;
    take_mid   = 1'b0;
    complete   = 1'b0;
`ifdef DESCHEDULER_FRAME_ERR_EN
    err        = 1'b0;
`endif
    if (valid_in) begin
      unique case (state)
        HUNT: begin
          if (sof_in) begin
            take_sof   = 1'b1;
            next_state = COLLECT;
          end else begin
`ifdef DESCHEDULER_FRAME_ERR_EN
            err = 1'b1;   // dropped while unaligned
`endif
          end
        end
        COLLECT: begin
          if (sof_in) begin
            // Truncated frame: the partial frame is abandoned. It is never
            // published, because r0..r3 load only on completion.
            take_sof = 1'b1;
`ifdef DESCHEDULER_FRAME_ERR_EN
            err      = 1'b1;
`endif
          end else if (ctr == LAST_LANE) begin
            complete   = 1'b1;
            next_state = HUNT;
          end else begin
            take_mid = 1'b1;
          end
        end
        default: next_state = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= next_state;
  end

  // NOTE: the shadow registers are reset like the control state. After reset
  // they read zero, so a frame abandoned by reset leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr       <= '0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      r0        <= '0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      valid_out <= 1'b0;
`ifdef DESCHEDULER_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      valid_out <= complete;
`ifdef DESCHEDULER_FRAME_ERR_EN
      frame_err <= err;
`endif
      if (take_sof) begin
        s0  <= data_in;
        ctr <= CTR_W'(1);
      end else if (take_mid) begin
        if (ctr == CTR_W'(1)) s1 <= data_in;
        else                  s2 <= data_in;
        ctr <= ctr + CTR_W'(1);
      end else if (complete) begin
        // Lane 3 goes straight to r3 on the same edge that publishes the
        // frame, so no extra cycle of latency is added.
        r0  <= s0;
        r1  <= s1;
        r2  <= s2;
        r3  <= data_in;
        ctr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_descheduler.sv
// -----------------------------------------------------------------------------
// tb_descheduler
//
// Self-checking bench for descheduler. It has three parts:
//   - a table of directed vectors: single frame, back-to-back frames,
//     truncated frame, and a non-sof word while unaligned;
//   - hand-written sequences: a mid-frame stall gap, and an asynchronous
//     reset taken mid-frame;
//   - random traffic compared against a frame-assembly reference model.
// frame_err is connected and checked only when DESCHEDULER_FRAME_ERR_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_descheduler;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          sof_in;
  logic [DW-1:0] r0, r1, r2, r3;
  logic          valid_out;
`ifdef DESCHEDULER_FRAME_ERR_EN
  logic          frame_err;
`endif

  descheduler #(.DATA_WIDTH(DW), .OUTPUTS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .sof_in    (sof_in),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
`ifdef DESCHEDULER_FRAME_ERR_EN
    .valid_out (valid_out),
    .frame_err (frame_err)
`else
    .valid_out (valid_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare every output against the given expected values.
  task automatic check_outs(input string name, input logic [4*DW-1:0] exp_r,
                            input logic exp_v, input logic exp_e);
    check({name, ".r"}, {r0, r1, r2, r3}, exp_r);
    check({name, ".valid_out"}, 64'(valid_out), 64'(exp_v));
`ifdef DESCHEDULER_FRAME_ERR_EN
    check({name, ".frame_err"}, 64'(frame_err), 64'(exp_e));
`else
    if (exp_e) begin end  // frame_err does not exist in this build
`endif
  endtask

  // ---------------- reference model ----------------
  // Words of the frame being gathered. Empty means the stream is unaligned.
  logic [DW-1:0] frag[$];
  logic [DW-1:0] m_r[4];
  logic          m_v, m_e;

  task automatic model_reset();
    frag.delete();
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_v = 1'b0;
    m_e = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [DW-1:0] d);
    m_v = 1'b0;
    m_e = 1'b0;
    if (v) begin
      if (s) begin
        if (frag.size() != 0) m_e = 1'b1;   // truncated frame
        frag.delete();
        frag.push_back(d);
      end else if (frag.size() == 0) begin
        m_e = 1'b1;                          // dropped while unaligned
      end else begin
        frag.push_back(d);
        if (frag.size() == 4) begin
          for (int i = 0; i < 4; i++) m_r[i] = frag[i];
          m_v = 1'b1;
          frag.delete();
        end
      end
    end
  endtask

  // Drive one cycle of input. Outputs are sampled #1 after the edge.
  task automatic apply(input logic v, input logic s, input logic [DW-1:0] d);
    valid_in = v;
    sof_in   = s;
    data_in  = d;
    @(posedge clk);
    #1;
    model_step(v, s, d);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic          s;
    logic [DW-1:0] d;
    logic          ev;
    logic          ee;
    logic [4*DW-1:0] er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic s, input logic [DW-1:0] d,
                     input logic ev, input logic ee, input logic [4*DW-1:0] er);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.ev = ev; t.ee = ee; t.er = er;
    tbl.push_back(t);
  endtask

  initial begin
    logic [4*DW-1:0] ra, rb, rc, rd;
    ra = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rb = {16'hA001, 16'hA002, 16'hA003, 16'hA004};
    rc = {16'hB001, 16'hB002, 16'hB003, 16'hB004};
    rd = {16'hC001, 16'hC002, 16'hC003, 16'hC004};

    // Single frame A1..A4.
    add(1, 1, 16'h1111, 0, 0, '0);
    add(1, 0, 16'h2222, 0, 0, '0);
    add(1, 0, 16'h3333, 0, 0, '0);
    add(1, 0, 16'h4444, 1, 0, ra);
    // Two frames back to back, with no idle cycle.
    add(1, 1, 16'hA001, 0, 0, ra);
    add(1, 0, 16'hA002, 0, 0, ra);
    add(1, 0, 16'hA003, 0, 0, ra);
    add(1, 0, 16'hA004, 1, 0, rb);
    add(1, 1, 16'hB001, 0, 0, rb);
    add(1, 0, 16'hB002, 0, 0, rb);
    add(1, 0, 16'hB003, 0, 0, rb);
    add(1, 0, 16'hB004, 1, 0, rc);
    // Truncated frame: E1(sof), E2, then C1(sof) restarts the frame.
    add(1, 1, 16'hE001, 0, 0, rc);
    add(1, 0, 16'hE002, 0, 0, rc);
    add(1, 1, 16'hC001, 0, 1, rc);
    add(1, 0, 16'hC002, 0, 0, rc);
    add(1, 0, 16'hC003, 0, 0, rc);
    add(1, 0, 16'hC004, 1, 0, rd);
    // Non-sof word while unaligned: dropped.
    add(1, 0, 16'h1234, 0, 1, rd);
    add(0, 0, 16'hFFFF, 0, 0, rd);
    // A sof with valid_in low is ignored, so the next lane-0-less word drops.
    add(0, 1, 16'h5555, 0, 0, rd);
    add(1, 0, 16'h6666, 0, 1, rd);

    valid_in = 0; sof_in = 0; data_in = '0; rst = 1'b0;
    model_reset();

    // Reset is asynchronous: outputs must clear before any clock edge.
    #2 rst = 1'b1;
    #1 check_outs("reset", '0, 0, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Table vectors.
    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].s, tbl[i].d);
      check_outs($sformatf("tbl%0d", i), tbl[i].er, tbl[i].ev, tbl[i].ee);
    end

    // Stall: three idle cycles between lanes 1 and 2.
    apply(1, 1, 16'h1111); check_outs("gap.l0", rd, 0, 0);
    apply(1, 0, 16'h2222); check_outs("gap.l1", rd, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 16'hDEAD);
      check_outs($sformatf("gap.idle%0d", i), rd, 0, 0);
    end
    apply(1, 0, 16'h3333); check_outs("gap.l2", rd, 0, 0);
    apply(1, 0, 16'h4444); check_outs("gap.l3", ra, 1, 0);
    apply(0, 0, 16'h0000); check_outs("gap.after", ra, 0, 0);

    // Asynchronous reset after lane 2 of a frame.
    apply(1, 1, 16'h7001);
    apply(1, 0, 16'h7002);
    apply(1, 0, 16'h7003);
    check_outs("rstmid.pre", ra, 0, 0);
    #2 rst = 1'b1;
    #1 check_outs("rstmid.async", '0, 0, 0);
    model_reset();
    #2 rst = 1'b0;
    // The pending lane 3 must not complete anything. It is dropped as unaligned.
    apply(1, 0, 16'h7004); check_outs("rstmid.drop", '0, 0, 1);
    apply(1, 1, 16'h8001);
    apply(1, 0, 16'h8002);
    apply(1, 0, 16'h8003);
    apply(1, 0, 16'h8004);
    check_outs("rstmid.frame", {16'h8001, 16'h8002, 16'h8003, 16'h8004}, 1, 0);

    // Random traffic compared against the model.
    for (int n = 0; n < 400; n++) begin
      logic v, s;
      logic [DW-1:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) == 0);
      d = DW'($urandom);
      apply(v, s, d);
      check_outs($sformatf("rnd%0d", n), {m_r[0], m_r[1], m_r[2], m_r[3]}, m_v, m_e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
